// File: rtl/segment_mem_wb_pipe.sv
// Elastic MEM->WB pipeline segment: two-entry (head + skid) valid/ready buffer
// carrying R lanes of N-bit data plus MEM control/flags, with flush and a stall counter.
module segment_mem_wb_pipe #(
  parameter int N  = 8,
  parameter int R  = 6,
  parameter int A  = 4,
  parameter int SC = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           validM,
  output logic           readyM,
  input  logic           RegWriteM,
  input  logic           MemtoRegM,
  input  logic           FlagsWriteM,
  input  logic           LDFlagM,
  input  logic [1:0]     ALUFlagsM,
  input  logic [1:0]     VSIFlagM,
  input  logic [A-1:0]   WA3M,
  input  logic [R-1:0]   LaneMaskM,
  input  logic [R*N-1:0] ReadDataM,
  input  logic [R*N-1:0] ALUOutputM,
  output logic           validW,
  input  logic           readyW,
  output logic           RegWriteW,
  output logic           MemtoRegW,
  output logic           FlagsWriteW,
  output logic           LDFlagW,
  output logic [1:0]     ALUFlagsW,
  output logic [1:0]     VSIFlagW,
  output logic [A-1:0]   WA3W,
  output logic [R-1:0]   LaneMaskW,
  output logic [R*N-1:0] ReadDataW,
  output logic [R*N-1:0] ALUOutputW,
  output logic [R*N-1:0] ResultW,
  output logic [R-1:0]   LaneWEW,
  output logic [1:0]     OccW,
  output logic [SC-1:0]  StallCountW
);

  // Handshake: a transfer happens on a clk edge where valid and ready are both
  // high; ready never depends combinationally on the opposite side's valid/ready.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic           reg_write;
    logic           mem_to_reg;
    logic           flags_write;
    logic           ld_flag;
    logic [1:0]     alu_flags;
    logic [1:0]     vsi_flag;
    logic [A-1:0]   wa3;
    logic [R-1:0]   lane_mask;
    logic [R*N-1:0] read_data;
    logic [R*N-1:0] alu_out;
  } entry_t;

  state_t        state, state_next;
  entry_t        head, skid, m_entry;
  logic          accept_m, release_w;
  logic          load_head_m, load_head_skid, load_skid;
  logic [SC-1:0] stall_cnt;

  assign m_entry = '{
    reg_write:   RegWriteM,
    mem_to_reg:  MemtoRegM,
    flags_write: FlagsWriteM,
    ld_flag:     LDFlagM,
    alu_flags:   ALUFlagsM,
    vsi_flag:    VSIFlagM,
    wa3:         WA3M,
    lane_mask:   LaneMaskM,
    read_data:   ReadDataM,
    alu_out:     ALUOutputM
  };

  assign readyM    = !reset && (state != FULL);
  assign validW    = (state != EMPTY);
  assign accept_m  = validM && readyM;
  assign release_w = validW && readyW;

  always_comb begin
    state_next     = state;
    load_head_m    = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_m) begin
            state_next  = ONE;
            load_head_m = 1'b1;
          end
        end
        ONE: begin
          if (accept_m && release_w) begin
            load_head_m = 1'b1;
          end else if (accept_m) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (release_w) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (release_w) begin
            state_next     = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // All segment state moves on the falling edge, like the neighbouring stages.
  always_ff @(negedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_m)         head <= m_entry;
      else if (load_head_skid) head <= skid;
      if (load_skid)           skid <= m_entry;
    end
  end

  // Saturating; flush deliberately leaves it alone.
  always_ff @(negedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (validM && !readyM && (stall_cnt != {SC{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(SC-1){1'b0}}, 1'b1};
    end
  end

  assign OccW        = state;
  assign StallCountW = stall_cnt;

  // Write enables are gated by validW; data fields stay stale when empty.
  assign RegWriteW   = head.reg_write & validW;
  assign FlagsWriteW = head.flags_write & validW;
  assign MemtoRegW   = head.mem_to_reg;
  assign LDFlagW     = head.ld_flag;
  assign ALUFlagsW   = head.alu_flags;
  assign VSIFlagW    = head.vsi_flag;
  assign WA3W        = head.wa3;
  assign LaneMaskW   = head.lane_mask;
  assign ReadDataW   = head.read_data;
  assign ALUOutputW  = head.alu_out;
  assign ResultW     = head.mem_to_reg ? head.read_data : head.alu_out;
  assign LaneWEW     = head.lane_mask & {R{head.reg_write & validW}};

endmodule

// File: tb/tb_segment_mem_wb_pipe.sv
// Bench for segment_mem_wb_pipe: vector table for the main flows, hand sequences
// for flush/saturation/reset, and a queue scoreboard under random backpressure.
module tb_segment_mem_wb_pipe;
  localparam int N  = 8;
  localparam int R  = 6;
  localparam int A  = 4;
  localparam int SC = 4;

  logic           clk = 1'b0;
  logic           reset, flush, validM, readyM, readyW, validW;
  logic           RegWriteM, MemtoRegM, FlagsWriteM, LDFlagM;
  logic [1:0]     ALUFlagsM, VSIFlagM;
  logic [A-1:0]   WA3M;
  logic [R-1:0]   LaneMaskM;
  logic [R*N-1:0] ReadDataM, ALUOutputM;
  logic           RegWriteW, MemtoRegW, FlagsWriteW, LDFlagW;
  logic [1:0]     ALUFlagsW, VSIFlagW;
  logic [A-1:0]   WA3W;
  logic [R-1:0]   LaneMaskW;
  logic [R*N-1:0] ReadDataW, ALUOutputW, ResultW;
  logic [R-1:0]   LaneWEW;
  logic [1:0]     OccW;
  logic [SC-1:0]  StallCountW;

  segment_mem_wb_pipe #(.N(N), .R(R), .A(A), .SC(SC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .validM(validM), .readyM(readyM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .FlagsWriteM(FlagsWriteM), .LDFlagM(LDFlagM),
    .ALUFlagsM(ALUFlagsM), .VSIFlagM(VSIFlagM), .WA3M(WA3M), .LaneMaskM(LaneMaskM),
    .ReadDataM(ReadDataM), .ALUOutputM(ALUOutputM),
    .validW(validW), .readyW(readyW),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FlagsWriteW(FlagsWriteW), .LDFlagW(LDFlagW),
    .ALUFlagsW(ALUFlagsW), .VSIFlagW(VSIFlagW), .WA3W(WA3W), .LaneMaskW(LaneMaskW),
    .ReadDataW(ReadDataW), .ALUOutputW(ALUOutputW), .ResultW(ResultW),
    .LaneWEW(LaneWEW), .OccW(OccW), .StallCountW(StallCountW)
  );

  // clock/reset block (reset is driven from the vectors)
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, fl, vm, rw, wr, m2r;
    logic [3:0] wa;
    logic [5:0] mask;
    logic [7:0] rd, alu;
    logic       e_vw, e_rm;
    logic [1:0] e_occ;
    logic [3:0] e_wa;
    logic [7:0] e_res;
    logic [5:0] e_lwe;
    logic [3:0] e_st;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  function automatic vec_t mk(
    input logic rst, fl, vm, rw, wr, m2r, input logic [3:0] wa, input logic [5:0] mask,
    input logic [7:0] rd, alu, input logic e_vw, e_rm, input logic [1:0] e_occ,
    input logic [3:0] e_wa, input logic [7:0] e_res, input logic [5:0] e_lwe,
    input logic [3:0] e_st);
    vec_t v;
    v.rst = rst; v.fl = fl; v.vm = vm; v.rw = rw; v.wr = wr; v.m2r = m2r;
    v.wa = wa; v.mask = mask; v.rd = rd; v.alu = alu;
    v.e_vw = e_vw; v.e_rm = e_rm; v.e_occ = e_occ; v.e_wa = e_wa;
    v.e_res = e_res; v.e_lwe = e_lwe; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver: called right after a posedge; applies inputs, waits one cycle
  // (the DUT updates on the negedge in between) and checks on the next posedge
  task automatic step(input vec_t v, input string tag);
    logic [47:0] exp_res;
    reset = v.rst; flush = v.fl; validM = v.vm; readyW = v.rw;
    RegWriteM = v.wr; MemtoRegM = v.m2r; FlagsWriteM = v.wr; LDFlagM = 1'b0;
    ALUFlagsM = 2'b10; VSIFlagM = 2'b01; WA3M = v.wa; LaneMaskM = v.mask;
    ReadDataM = {R{v.rd}}; ALUOutputM = {R{v.alu}};
    @(posedge clk);
    exp_res = {R{v.e_res}};
    chk({tag, "_validW"}, 64'(validW), 64'(v.e_vw));
    chk({tag, "_readyM"}, 64'(readyM), 64'(v.e_rm));
    chk({tag, "_occ"}, 64'(OccW), 64'(v.e_occ));
    chk({tag, "_wa3"}, 64'(WA3W), 64'(v.e_wa));
    chk({tag, "_result"}, 64'(ResultW), 64'(exp_res));
    chk({tag, "_lanewe"}, 64'(LaneWEW), 64'(v.e_lwe));
    chk({tag, "_stall"}, 64'(StallCountW), 64'(v.e_st));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({RegWriteW, MemtoRegW, FlagsWriteW, LDFlagW, ALUFlagsW, VSIFlagW}), 64'd0);
    chk({tag, "_mask"}, 64'(LaneMaskW), 64'd0);
    chk({tag, "_rdata"}, 64'(ReadDataW), 64'd0);
    chk({tag, "_aluout"}, 64'(ALUOutputW), 64'd0);
  endtask

  // scoreboard: observe one cycle's handshakes, compare releases in order
  task automatic sb_observe(input logic [7:0] tag);
    logic [7:0] e;
    #1;
    if (validW && readyW) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_release", 64'(WA3W), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wa3", 64'(WA3W), 64'(e[3:0]));
        chk("sb_result", 64'(ResultW), 64'({R{e}}));
      end
    end
    if (validM && readyM) exp_q.push_back(tag);
  endtask

  vec_t tbl[$];

  initial begin
    logic [7:0] tag;
    int k;
    reset = 1'b1; flush = 1'b0; validM = 1'b0; readyW = 1'b0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; FlagsWriteM = 1'b0; LDFlagM = 1'b0;
    ALUFlagsM = '0; VSIFlagM = '0; WA3M = '0; LaneMaskM = '0; ReadDataM = '0; ALUOutputM = '0;
    @(posedge clk);

    // reset held two cycles
    step(mk(1,0,0,0,0,0,0,6'h00,8'h00,8'h00, 0,0,0,0,8'h00,6'h00,0), "rst0");
    step(mk(1,0,0,0,0,0,0,6'h00,8'h00,8'h00, 0,0,0,0,8'h00,6'h00,0), "rst1");
    check_zero("rst");

    // rst, fl, vm, rw, wr, m2r, wa, mask, rd, alu | vw, rm, occ, wa, res, lwe, stall
    tbl.push_back(mk(0,0,0,0,0,0, 0,6'h3F,8'hA5,8'h00, 0,1,0, 0,8'h00,6'h00,0));
    // streaming
    tbl.push_back(mk(0,0,1,1,1,1, 1,6'h3F,8'hA5,8'h3C, 1,1,1, 1,8'hA5,6'h3F,0));
    tbl.push_back(mk(0,0,1,1,1,1, 2,6'h3F,8'hA5,8'h3C, 1,1,1, 2,8'hA5,6'h3F,0));
    tbl.push_back(mk(0,0,1,1,1,1, 3,6'h3F,8'hA5,8'h3C, 1,1,1, 3,8'hA5,6'h3F,0));
    tbl.push_back(mk(0,0,0,1,1,1, 0,6'h3F,8'hA5,8'h3C, 0,1,0, 3,8'hA5,6'h00,0));
    // backpressure
    tbl.push_back(mk(0,0,1,0,1,0, 4,6'h3F,8'hA5,8'h44, 1,1,1, 4,8'h44,6'h3F,0));
    tbl.push_back(mk(0,0,1,0,1,0, 5,6'h3F,8'hA5,8'h55, 1,0,2, 4,8'h44,6'h3F,0));
    tbl.push_back(mk(0,0,1,0,1,0, 6,6'h3F,8'hA5,8'h66, 1,0,2, 4,8'h44,6'h3F,1));
    tbl.push_back(mk(0,0,1,0,1,0, 6,6'h3F,8'hA5,8'h66, 1,0,2, 4,8'h44,6'h3F,2));
    tbl.push_back(mk(0,0,1,1,1,0, 6,6'h3F,8'hA5,8'h66, 1,1,1, 5,8'h55,6'h3F,3));
    tbl.push_back(mk(0,0,1,1,1,0, 6,6'h3F,8'hA5,8'h66, 1,1,1, 6,8'h66,6'h3F,3));
    tbl.push_back(mk(0,0,0,1,1,0, 0,6'h3F,8'hA5,8'h00, 0,1,0, 6,8'h66,6'h00,3));
    // masking and RegWrite gating
    tbl.push_back(mk(0,0,1,0,1,0, 7,6'h05,8'hA5,8'h77, 1,1,1, 7,8'h77,6'h05,3));
    tbl.push_back(mk(0,0,0,1,1,0, 0,6'h3F,8'hA5,8'h00, 0,1,0, 7,8'h77,6'h00,3));
    tbl.push_back(mk(0,0,1,0,0,0, 8,6'h3F,8'hA5,8'h88, 1,1,1, 8,8'h88,6'h00,3));
    tbl.push_back(mk(0,0,0,1,0,0, 0,6'h3F,8'hA5,8'h00, 0,1,0, 8,8'h88,6'h00,3));
    // flush in FULL with readyW=1: skid entry 10 must never appear
    tbl.push_back(mk(0,0,1,0,1,0, 9,6'h3F,8'hA5,8'h99, 1,1,1, 9,8'h99,6'h3F,3));
    tbl.push_back(mk(0,0,1,0,1,0,10,6'h3F,8'hA5,8'hAA, 1,0,2, 9,8'h99,6'h3F,3));
    tbl.push_back(mk(0,1,1,1,1,0,11,6'h3F,8'hA5,8'hBB, 0,1,0, 9,8'h99,6'h00,4));
    tbl.push_back(mk(0,0,0,1,1,0, 0,6'h3F,8'hA5,8'h00, 0,1,0, 9,8'h99,6'h00,4));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // saturation: fill, then hold validM with readyM low for 20 cycles
    step(mk(0,0,1,0,1,0,1,6'h3F,8'hA5,8'h11, 1,1,1,1,8'h11,6'h3F,4), "sat_fill0");
    step(mk(0,0,1,0,1,0,2,6'h3F,8'hA5,8'h22, 1,0,2,1,8'h11,6'h3F,4), "sat_fill1");
    for (int c = 1; c <= 20; c++) begin
      k = (4 + c > 15) ? 15 : 4 + c;
      step(mk(0,0,1,0,1,0,3,6'h3F,8'hA5,8'h33, 1,0,2,1,8'h11,6'h3F,4'(k)), $sformatf("sat%0d", c));
    end
    step(mk(0,1,0,0,1,0,0,6'h3F,8'hA5,8'h00, 0,1,0,1,8'h11,6'h00,15), "sat_flush");
    step(mk(0,0,1,0,1,0,5,6'h3F,8'hA5,8'h55, 1,1,1,5,8'h55,6'h3F,15), "sat_after");
    // reset mid-operation clears everything, nothing emerges afterwards
    step(mk(1,0,1,0,1,0,6,6'h3F,8'hA5,8'h66, 0,0,0,0,8'h00,6'h00,0), "midrst");
    check_zero("midrst");
    step(mk(0,0,0,1,1,0,0,6'h3F,8'hA5,8'h00, 0,1,0,0,8'h00,6'h00,0), "postrst0");
    step(mk(0,0,0,1,1,0,0,6'h3F,8'hA5,8'h00, 0,1,0,0,8'h00,6'h00,0), "postrst1");

    // random handshakes, FIFO order checked against exp_q
    tag = 8'h01;
    for (int c = 0; c < 200; c++) begin
      reset = 1'b0; flush = 1'b0;
      validM = 1'($urandom_range(0, 1)); readyW = 1'($urandom_range(0, 1));
      RegWriteM = 1'b1; MemtoRegM = 1'b0; WA3M = tag[3:0]; LaneMaskM = 6'h3F;
      ReadDataM = {R{8'hA5}}; ALUOutputM = {R{tag}};
      sb_observe(tag);
      if (validM && readyM) tag = tag + 8'd1;
      @(posedge clk);
    end
    validM = 1'b0; readyW = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sb_observe(tag);
      @(posedge clk);
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
